hpram_cmd_arbiter: RTL
======================

Name: hpram_cmd_arbiter

Overview:
- Shares the single HyperRAM memory-interface command port between two DMA requesters: requester 0 is the video-in write path, requester 1 is the video-out read path.
- Runs in the HyperRAM user clock domain (the memory-interface clk_out).
- Round-robin arbitration, fixed-length write/read bursts, a read-completion watchdog and a command recovery gap.
- Gated by memory calibration: no command issues until calibration completes.

Parameters:
AW, 22, address width
DW, 32, data width
WR_BEATS, 4, data beats per write command (>=1)
RD_BEATS, 4, rd_data_valid beats expected per read command (>=1)
TCMD_GAP, 2, idle cycles forced after each transaction (>=0)
TIMEOUT, 255, max cycles in RWAIT before abort

Ports:
I_clk  in  1  HyperRAM user clock; all logic on rising edge
I_rst_n  in  1  asynchronous active-low reset
I_init_calib  in  1  memory calibrated; sampled only in IDLE
I_req0 / I_req1  in  1  request; held high until matching O_gnt pulse
I_wr0 / I_wr1  in  1  1=write, 0=read; valid with request
I_addr0 / I_addr1  in  AW  burst start address; valid with request
I_wr_data0 / I_wr_data1  in  DW  write beat; must be valid in any cycle its O_wr_ack is high
O_gnt0 / O_gnt1  out  1  one-cycle grant pulse, coincident with O_cmd_en
O_wr_ack0 / O_wr_ack1  out  1  write beat consumed this cycle
O_rd_valid0 / O_rd_valid1  out  1  O_rd_data valid for this requester
O_rd_data  out  DW  registered copy of I_rd_data
O_cmd  out  1  1=write, 0=read
O_cmd_en  out  1  command strobe
O_addr  out  AW  command address
O_wr_data  out  DW  write data to memory
O_data_mask  out  DW/8  write byte mask; constant 0
I_rd_data_valid  in  1  read beat valid from memory
I_rd_data  in  DW  read beat from memory
O_busy  out  1  state != IDLE
O_err  out  2  sticky flags: [0] read timeout, [1] stray rd_data_valid; cleared only by reset

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = 0 (requester 0 preferred), all counters 0.
- States: IDLE, CMD, WDATA, RWAIT, GAP.
- No combinational path from I_req*/I_wr* to O_cmd_en, O_cmd or O_addr; these are driven from registers.

IDLE:
- If I_init_calib=0, stay.
- Else if exactly one request is high, grant it; if both are high, grant the requester named by the pointer.
- On grant, latch g, I_wr[g] and I_addr[g]; go to CMD next cycle (1-cycle latency from request to O_cmd_en).

CMD (1 cycle):
- O_cmd_en=1, O_gnt[g]=1, O_cmd and O_addr from latches.
- Write: O_wr_ack[g]=1, O_wr_data=I_wr_data[g] (combinational mux), beat count = 1. Next state WDATA if WR_BEATS>1, else GAP.
- Read: next state RWAIT; clear read-beat and timeout counters.

WDATA:
- O_wr_ack[g]=1 and O_wr_data=I_wr_data[g] every cycle.
- After beat WR_BEATS, go to GAP.
- Write beats occupy WR_BEATS consecutive cycles starting at the CMD cycle, with no gaps.

RWAIT:
- Each I_rd_data_valid: next cycle O_rd_data=I_rd_data and O_rd_valid[g]=1; increment beat count.
- On the RD_BEATS-th valid, go to GAP.
- Timeout counter increments every RWAIT cycle. When it reaches TIMEOUT, set O_err[0] and go to GAP; the requester has then received fewer than RD_BEATS beats.

GAP:
- Hold for TCMD_GAP cycles; TCMD_GAP=0 means return to IDLE immediately.
- On exit, pointer = ~g.

Stray read data:
- I_rd_data_valid in any state other than RWAIT sets O_err[1]; the data is dropped and no O_rd_valid is asserted.

Other rules:
- I_init_calib falling mid-transaction: the current transaction completes; the new value is honoured in IDLE.
- Fairness: with both requesters continuously requesting, grants strictly alternate. Worst-case wait for a requester is one full transaction plus TCMD_GAP.
- Reset asserted mid-operation: everything clears immediately to reset values, with no completion of the burst in flight.
- I_req dropped before grant: legal; nothing is granted. Dropped after the grant cycle: ignored.

Test Plan:
1. Calibration gating: I_init_calib=0, I_req0=1 for 50 cycles -> no O_cmd_en; raise calib -> O_cmd_en 1 cycle later.
2. Single write: calib=1, req0 write, addr=0x000100, data 0xA0..0xA3 -> one O_cmd_en with O_cmd=1 and O_addr=0x000100; O_wr_ack0 high 4 consecutive cycles; O_wr_data=0xA0..0xA3; O_data_mask=0; O_busy low after 2 GAP cycles.
3. Single read: req1 read, addr=0x003C00; memory returns 4 valids with 0x11..0x44 after 7 cycles -> O_rd_valid1 x4 (one cycle after each valid) carrying 0x11..0x44; O_rd_valid0 stays 0.
4. Contention: req0 and req1 held high continuously -> grant order 0,1,0,1 over 4 transactions; O_gnt0 and O_gnt1 never both high.
5. Faults:
   - Read with only 2 valids returned -> O_err=2'b01 after 255 RWAIT cycles; returns to IDLE; the next request is served.
   - A valid pulse in IDLE -> O_err[1]=1.
6. Reset mid-burst: assert I_rst_n=0 during WDATA beat 2 -> all outputs 0 asynchronously; after release, state is IDLE and requester 0 wins a simultaneous request.

Source files
------------

// File: rtl/hpram_cmd_arbiter.sv
// Two-requester command arbiter for the HyperRAM user port.
// Round-robin grant, fixed-length bursts, read watchdog and post-transaction gap.
module hpram_cmd_arbiter #(
  parameter int AW       = 22,
  parameter int DW       = 32,
  parameter int WR_BEATS = 4,
  parameter int RD_BEATS = 4,
  parameter int TCMD_GAP = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic            I_init_calib,
  input  logic            I_req0,
  input  logic            I_req1,
  input  logic            I_wr0,
  input  logic            I_wr1,
  input  logic [AW-1:0]   I_addr0,
  input  logic [AW-1:0]   I_addr1,
  input  logic [DW-1:0]   I_wr_data0,
  input  logic [DW-1:0]   I_wr_data1,
  output logic            O_gnt0,
  output logic            O_gnt1,
  output logic            O_wr_ack0,
  output logic            O_wr_ack1,
  output logic            O_rd_valid0,
  output logic            O_rd_valid1,
  output logic [DW-1:0]   O_rd_data,
  output logic            O_cmd,
  output logic            O_cmd_en,
  output logic [AW-1:0]   O_addr,
  output logic [DW-1:0]   O_wr_data,
  output logic [DW/8-1:0] O_data_mask,
  input  logic            I_rd_data_valid,
  input  logic [DW-1:0]   I_rd_data,
  output logic            O_busy,
  output logic [1:0]      O_err
);

  // state | meaning
  // IDLE  | waiting for calibration and a request
  // CMD   | command strobe and grant; first write beat
  // WDATA | remaining write beats
  // RWAIT | collecting read beats, watchdog running
  // GAP   | recovery idle cycles before next arbitration

  localparam int BMAX = (WR_BEATS > RD_BEATS) ? WR_BEATS : RD_BEATS;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int GW   = (TCMD_GAP < 1) ? 1 : $clog2(TCMD_GAP + 1);

  localparam logic [BW-1:0] WR_LAST  = BW'(WR_BEATS - 1);
  localparam logic [BW-1:0] RD_LAST  = BW'(RD_BEATS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(TCMD_GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RWAIT, GAP} state_t;

  state_t        state;
  logic          g;
  logic          ptr;
  logic          wr_ack;
  logic [BW-1:0] beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic          any_req;
  logic          pick;

  assign any_req = I_req0 | I_req1;
  assign pick    = (I_req0 & I_req1) ? ptr : I_req1;

  // write data is consumed in the same cycle it is acknowledged
  assign O_wr_ack0   = wr_ack & ~g;
  assign O_wr_ack1   = wr_ack & g;
  assign O_wr_data   = wr_ack ? (g ? I_wr_data1 : I_wr_data0) : '0;
  assign O_data_mask = '0;
  assign O_busy      = (state != IDLE);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= IDLE;
      g           <= 1'b0;
      ptr         <= 1'b0;
      wr_ack      <= 1'b0;
      beat_cnt    <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      O_gnt0      <= 1'b0;
      O_gnt1      <= 1'b0;
      O_cmd_en    <= 1'b0;
      O_cmd       <= 1'b0;
      O_addr      <= '0;
      O_rd_valid0 <= 1'b0;
      O_rd_valid1 <= 1'b0;
      O_rd_data   <= '0;
      O_err       <= 2'b00;
    end else begin
      O_gnt0      <= 1'b0;
      O_gnt1      <= 1'b0;
      O_cmd_en    <= 1'b0;
      O_rd_valid0 <= 1'b0;
      O_rd_valid1 <= 1'b0;

      if (I_rd_data_valid && state != RWAIT) O_err[1] <= 1'b1;

      case (state)
        IDLE: begin
          if (I_init_calib && any_req) begin
            g        <= pick;
            O_cmd    <= pick ? I_wr1 : I_wr0;
            O_addr   <= pick ? I_addr1 : I_addr0;
            wr_ack   <= pick ? I_wr1 : I_wr0;
            O_cmd_en <= 1'b1;
            O_gnt0   <= ~pick;
            O_gnt1   <= pick;
            state    <= CMD;
          end
        end

        CMD: begin
          tmo_cnt  <= '0;
          beat_cnt <= O_cmd ? BW'(1) : '0;
          if (!O_cmd) begin
            state <= RWAIT;
          end else if (WR_BEATS > 1) begin
            state <= WDATA;
          end else begin
            wr_ack <= 1'b0;
            if (TCMD_GAP == 0) begin
              state <= IDLE;
              ptr   <= ~g;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end

        WDATA: begin
          if (beat_cnt == WR_LAST) begin
            wr_ack <= 1'b0;
            if (TCMD_GAP == 0) begin
              state <= IDLE;
              ptr   <= ~g;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        RWAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (I_rd_data_valid) begin
            O_rd_data   <= I_rd_data;
            O_rd_valid0 <= ~g;
            O_rd_valid1 <= g;
            beat_cnt    <= beat_cnt + 1'b1;
          end
          // a final beat landing on the watchdog limit still counts as a clean finish
          if ((I_rd_data_valid && beat_cnt == RD_LAST) || tmo_cnt == TMO_LAST) begin
            if (!(I_rd_data_valid && beat_cnt == RD_LAST)) O_err[0] <= 1'b1;
            if (TCMD_GAP == 0) begin
              state <= IDLE;
              ptr   <= ~g;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_ONE) begin
            state <= IDLE;
            ptr   <= ~g;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
